// File: rtl/mcdp_pkg.sv
// mcdp_pkg
// Shared definitions for the multicycle MIPS-subset core: opcode and funct
// encodings, controller state enumeration, ALU operation enumeration and the
// 16-bit immediate sign-extension helper.
// Optional feature macro used by the core: MCDP_JAL_EN (enables jal decode).
package mcdp_pkg;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instruction bits [5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_JR,
        S_JAL
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT
    } aluop_e;

    // Widest supported datapath is 64 bits; callers cast down to XLEN.
    function automatic logic [63:0] sext16(input logic [15:0] imm);
        return {{48{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mcdp_if.sv
// mcdp_if
// Memory handshake bundle between the core and the unified instruction/data
// memory. A transfer completes on a rising clock edge where memReq and
// memReady are both high.
//   memReq    core -> mem   access request
//   memWE     core -> mem   write enable, meaningful only with memReq
//   memAddr   core -> mem   byte address
//   memWData  core -> mem   store data
//   memRData  mem  -> core  read data, valid whenever memReady is high
//   memReady  mem  -> core  access completes this cycle
// Modports: master (core side), slave (memory side).
interface mcdp_if #(
    parameter int XLEN = 32
);
    logic            memReq;
    logic            memWE;
    logic [XLEN-1:0] memAddr;
    logic [XLEN-1:0] memWData;
    logic [XLEN-1:0] memRData;
    logic            memReady;

    modport master (
        output memReq, memWE, memAddr, memWData,
        input  memRData, memReady
    );

    modport slave (
        input  memReq, memWE, memAddr, memWData,
        output memRData, memReady
    );
endinterface

// File: rtl/mcdp_alu.sv
// mcdp_alu
// Purely combinational XLEN-wide ALU for the multicycle core.
//   i_op    operation select (add/sub/and/or/nor/slt)
//   i_a     first operand
//   i_b     second operand
//   o_y     result; slt yields 0 or 1 from a signed comparison
//   o_zero  high when o_y is all zeros (used for beq via subtraction)
module mcdp_alu
    import mcdp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  aluop_e          i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_y,
    output logic            o_zero
);

    always_comb begin
        o_y = '0;
        case (i_op)
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_NOR: o_y = ~(i_a | i_b);
            ALU_SLT: o_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: o_y = '0;
        endcase
    end

    assign o_zero = (o_y == '0);

endmodule

// File: rtl/mcdp_core.sv
// mcdp_core
// Multicycle MIPS-subset datapath plus controller sharing a single memory
// port for instruction fetch and data access. Holds PC, IR, MDR, A, B and
// ALUOut plus an NREGS-entry register file; every memory access may stall
// on memReady.
//   clock    sole clock, rising edge
//   resetN   asynchronous active-low reset
//   mem      memory handshake (mcdp_if.master)
//   pcQ      current PC
//   instr    instruction register
//   illegal  one-cycle pulse after an undecodable opcode/funct
// Optional feature: define MCDP_JAL_EN to decode opcode 000011 as jal
// (link into the highest register); otherwise that opcode is illegal.
module mcdp_core
    import mcdp_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            resetN,
    mcdp_if.master          mem,
    output logic [XLEN-1:0] pcQ,
    output logic [31:0]     instr,
    output logic            illegal
);

    localparam int RW = $clog2(NREGS);

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_mdr;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_aluOut;
    logic            r_memReq;
    logic            r_memWE;
    logic [XLEN-1:0] r_memAddr;
    logic            r_illegal;
    logic [XLEN-1:0] r_regs [NREGS];

    logic [5:0]      w_opcode;
    logic [5:0]      w_funct;
    logic [RW-1:0]   w_rs;
    logic [RW-1:0]   w_rt;
    logic [RW-1:0]   w_rd;
    logic [XLEN-1:0] w_immExt;
    logic [XLEN-1:0] w_pcPlus4;
    logic [XLEN-1:0] w_jumpTarget;
    logic [XLEN-1:0] w_rsVal;
    logic [XLEN-1:0] w_rtVal;
    aluop_e          w_functOp;
    logic            w_functLegal;
    aluop_e          w_aluOp;
    logic [XLEN-1:0] w_aluB;
    logic [XLEN-1:0] w_aluY;
    logic            w_aluZero;
    logic            w_regWe;
    logic [RW-1:0]   w_regWAddr;
    logic [XLEN-1:0] w_regWData;

    assign w_opcode     = r_ir[31:26];
    assign w_funct      = r_ir[5:0];
    assign w_rs         = r_ir[21 +: RW];
    assign w_rt         = r_ir[16 +: RW];
    assign w_rd         = r_ir[11 +: RW];
    assign w_immExt     = XLEN'(sext16(r_ir[15:0]));
    assign w_pcPlus4    = r_pc + XLEN'(4);
    // r_pc already points past the jump, so its top nibble is the region kept.
    assign w_jumpTarget = {r_pc[XLEN-1:28], r_ir[25:0], 2'b00};

    // Register 0 is hardwired to zero on the read side.
    assign w_rsVal = (w_rs == '0) ? '0 : r_regs[w_rs];
    assign w_rtVal = (w_rt == '0) ? '0 : r_regs[w_rt];

    always_comb begin
        w_functOp    = ALU_ADD;
        w_functLegal = 1'b1;
        case (w_funct)
            FN_ADD:  w_functOp = ALU_ADD;
            FN_SUB:  w_functOp = ALU_SUB;
            FN_AND:  w_functOp = ALU_AND;
            FN_OR:   w_functOp = ALU_OR;
            FN_NOR:  w_functOp = ALU_NOR;
            FN_SLT:  w_functOp = ALU_SLT;
            FN_JR:   w_functOp = ALU_ADD;
            default: w_functLegal = 1'b0;
        endcase
    end

    // Operand A is always register A; B switches to the immediate for
    // address and addi computation, and beq compares by subtraction.
    always_comb begin
        w_aluOp = ALU_ADD;
        w_aluB  = r_b;
        case (r_state)
            S_EXEC:             w_aluOp = w_functOp;
            S_MEMADR, S_ADDIEX: w_aluB  = w_immExt;
            S_BRANCH:           w_aluOp = ALU_SUB;
            default:            w_aluOp = ALU_ADD;
        endcase
    end

    mcdp_alu #(.XLEN(XLEN)) u_alu (
        .i_op   (w_aluOp),
        .i_a    (r_a),
        .i_b    (w_aluB),
        .o_y    (w_aluY),
        .o_zero (w_aluZero)
    );

    always_comb begin
        w_regWe    = 1'b0;
        w_regWAddr = '0;
        w_regWData = '0;
        case (r_state)
            S_MEMWB: begin
                w_regWe    = 1'b1;
                w_regWAddr = w_rt;
                w_regWData = r_mdr;
            end
            S_ALUWB: begin
                w_regWe    = 1'b1;
                w_regWAddr = w_rd;
                w_regWData = r_aluOut;
            end
            S_ADDIWB: begin
                w_regWe    = 1'b1;
                w_regWAddr = w_rt;
                w_regWData = r_aluOut;
            end
`ifdef MCDP_JAL_EN
            S_JAL: begin
                w_regWe    = 1'b1;
                w_regWAddr = RW'(NREGS - 1);
                w_regWData = r_pc;
            end
`endif
            default: w_regWe = 1'b0;
        endcase
    end

    // Writes addressed to register 0 are dropped so it stays zero.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_regWe && (w_regWAddr != '0)) begin
            r_regs[w_regWAddr] <= w_regWData;
        end
    end

    // Controller and non-architectural registers. The memory request outputs
    // are registered and loaded on the transition into each access state, so
    // they sit stable for the whole access while memReady is low. Reset
    // leaves a fetch of RESET_PC already armed.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_mdr     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_aluOut  <= '0;
            r_memReq  <= 1'b1;
            r_memWE   <= 1'b0;
            r_memAddr <= RESET_PC;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (mem.memReady) begin
                        r_ir     <= mem.memRData[31:0];
                        r_pc     <= w_pcPlus4;
                        r_memReq <= 1'b0;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a      <= w_rsVal;
                    r_b      <= w_rtVal;
                    r_aluOut <= r_pc + (w_immExt << 2);
                    case (w_opcode)
                        OP_RTYPE: begin
                            if (!w_functLegal) begin
                                r_illegal <= 1'b1;
                                r_memReq  <= 1'b1;
                                r_memWE   <= 1'b0;
                                r_memAddr <= r_pc;
                                r_state   <= S_FETCH;
                            end else if (w_funct == FN_JR) begin
                                r_state <= S_JR;
                            end else begin
                                r_state <= S_EXEC;
                            end
                        end
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
`ifdef MCDP_JAL_EN
                        OP_JAL:       r_state <= S_JAL;
`endif
                        default: begin
                            r_illegal <= 1'b1;
                            r_memReq  <= 1'b1;
                            r_memWE   <= 1'b0;
                            r_memAddr <= r_pc;
                            r_state   <= S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    r_aluOut  <= w_aluY;
                    r_memReq  <= 1'b1;
                    r_memAddr <= w_aluY;
                    r_memWE   <= (w_opcode == OP_SW);
                    r_state   <= (w_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    if (mem.memReady) begin
                        r_mdr    <= mem.memRData;
                        r_memReq <= 1'b0;
                        r_state  <= S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    r_memReq  <= 1'b1;
                    r_memAddr <= r_pc;
                    r_state   <= S_FETCH;
                end
                S_MEMWR: begin
                    if (mem.memReady) begin
                        r_memWE   <= 1'b0;
                        r_memAddr <= r_pc;
                        r_state   <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    r_aluOut <= w_aluY;
                    r_state  <= S_ALUWB;
                end
                S_ADDIEX: begin
                    r_aluOut <= w_aluY;
                    r_state  <= S_ADDIWB;
                end
                S_ALUWB, S_ADDIWB: begin
                    r_memReq  <= 1'b1;
                    r_memAddr <= r_pc;
                    r_state   <= S_FETCH;
                end
                S_BRANCH: begin
                    r_memReq  <= 1'b1;
                    r_state   <= S_FETCH;
                    if (w_aluZero) begin
                        r_pc      <= r_aluOut;
                        r_memAddr <= r_aluOut;
                    end else begin
                        r_memAddr <= r_pc;
                    end
                end
`ifdef MCDP_JAL_EN
                S_JUMP, S_JAL: begin
`else
                S_JUMP: begin
`endif
                    r_pc      <= w_jumpTarget;
                    r_memReq  <= 1'b1;
                    r_memAddr <= w_jumpTarget;
                    r_state   <= S_FETCH;
                end
                S_JR: begin
                    r_pc      <= r_a;
                    r_memReq  <= 1'b1;
                    r_memAddr <= r_a;
                    r_state   <= S_FETCH;
                end
                default: begin
                    r_memReq  <= 1'b1;
                    r_memWE   <= 1'b0;
                    r_memAddr <= r_pc;
                    r_state   <= S_FETCH;
                end
            endcase
        end
    end

    // Gating with resetN drops the request the instant reset is asserted.
    assign mem.memReq   = r_memReq & resetN;
    assign mem.memWE    = r_memWE & resetN;
    assign mem.memAddr  = r_memAddr;
    assign mem.memWData = r_b;
    assign pcQ          = r_pc;
    assign instr        = r_ir;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_mcdp_core.sv
// tb_mcdp_core
// Self-checking bench for mcdp_core (XLEN=32, NREGS=32, RESET_PC=0x100).
// The bench plays the memory: each access is served with a chosen number of
// stall cycles. An ISA-level register model predicts results; expected
// stores are queued when a sw is issued and compared when the core writes.
// Honours MCDP_JAL_EN for the jal scenario.
module tb_mcdp_core;

    localparam int          XLEN = 32;
    localparam logic [31:0] RPC  = 32'h0000_0100;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clock  = 1'b0;
    logic        resetN = 1'b0;
    logic [31:0] pcQ;
    logic [31:0] instr;
    logic        illegal;

    mcdp_if #(.XLEN(XLEN)) memBus ();

    mcdp_core #(
        .XLEN     (XLEN),
        .NREGS    (32),
        .RESET_PC (RPC)
    ) dut (
        .clock   (clock),
        .resetN  (resetN),
        .mem     (memBus),
        .pcQ     (pcQ),
        .instr   (instr),
        .illegal (illegal)
    );

    always #5 clock = ~clock;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;
    int illCount    = 0;
    int wrCount     = 0;

    logic [31:0] mReg [32];
    logic [31:0] mPc;
    logic [31:0] mMem [logic [31:0]];
    wr_t         sbq [$];

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (illegal === 1'b1) illCount <= illCount + 1;
    always @(posedge clock)
        if (memBus.memReq === 1'b1 && memBus.memWE === 1'b1 && memBus.memReady === 1'b1)
            wrCount <= wrCount + 1;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic setReg(input int idx, input logic [31:0] v);
        if (idx != 0) mReg[idx] = v;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 32; i++) mReg[i] = 32'h0;
        mPc = RPC;
    endtask

    // Serve one memory access; called at (or just after) a falling edge and
    // returns at the falling edge after the access completed.
    task automatic serveAccess(input logic isWrite, input logic [31:0] addr, input logic [31:0] rdata,
                               input int waits, input string tag, output int startCyc);
        int  n;
        wr_t e;
        n = 0;
        while (memBus.memReq !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        startCyc = cyc;
        nCompared++;
        if (memBus.memReq !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL %s request timeout: memReq=%b required 1", tag, memBus.memReq);
            return;
        end
        nCompared++;
        if (memBus.memAddr !== addr) begin
            nMismatched++;
            $display("[TB] FAIL %s addr: got %h required %h", tag, memBus.memAddr, addr);
        end
        nCompared++;
        if (memBus.memWE !== isWrite) begin
            nMismatched++;
            $display("[TB] FAIL %s memWE: got %b required %b", tag, memBus.memWE, isWrite);
        end
        for (int w = 0; w < waits; w++) begin
            @(negedge clock);
            nCompared++;
            if (memBus.memReq !== 1'b1 || memBus.memAddr !== addr || memBus.memWE !== isWrite) begin
                nMismatched++;
                $display("[TB] FAIL %s hold: req=%b we=%b addr=%h required 1/%b/%h",
                         tag, memBus.memReq, memBus.memWE, memBus.memAddr, isWrite, addr);
            end
        end
        memBus.memRData = rdata;
        memBus.memReady = 1'b1;
        if (isWrite) begin
            nCompared++;
            if (sbq.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL %s store: got unexpected write data %h required no write", tag, memBus.memWData);
            end else begin
                e = sbq.pop_front();
                if (memBus.memWData !== e.data || memBus.memAddr !== e.addr) begin
                    nMismatched++;
                    $display("[TB] FAIL %s store: got %h@%h required %h@%h",
                             tag, memBus.memWData, memBus.memAddr, e.data, e.addr);
                end
            end
        end
        @(posedge clock);
        #1;
        memBus.memReady = 1'b0;
        memBus.memRData = 32'h0;
        @(negedge clock);
    endtask

    // Run one instruction against the ISA model and check latency, next PC
    // and the illegal pulse.
    task automatic doInstr(input logic [31:0] ins, input int fWaits, input int dWaits, input string tag);
        int          s0, n, base, illBefore, rs, rt, rd;
        logic        ill;
        logic [5:0]  op, fn;
        logic [31:0] a, b, imm, p4, next, ea, rdv;
        op = ins[31:26];
        fn = ins[5:0];
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        rd = int'(ins[15:11]);
        a  = mReg[rs];
        b  = mReg[rt];
        imm  = {{16{ins[15]}}, ins[15:0]};
        p4   = mPc + 32'd4;
        next = p4;
        base = 4;
        ill  = 1'b0;
        illBefore = illCount;
        serveAccess(1'b0, mPc, ins, fWaits, {tag, "/fetch"}, s0);
        nCompared++;
        if (pcQ !== p4) begin
            nMismatched++;
            $display("[TB] FAIL %s pcQ after fetch: got %h required %h", tag, pcQ, p4);
        end
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: setReg(rd, a + b);
                    6'h22: setReg(rd, a - b);
                    6'h24: setReg(rd, a & b);
                    6'h25: setReg(rd, a | b);
                    6'h27: setReg(rd, ~(a | b));
                    6'h2A: setReg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    6'h08: begin next = a; base = 3; end
                    default: begin ill = 1'b1; base = 2; end
                endcase
            end
            6'h08: setReg(rt, a + imm);
            6'h23: begin
                base = 5;
                ea   = a + imm;
                rdv  = mMem.exists(ea) ? mMem[ea] : 32'h0;
                serveAccess(1'b0, ea, rdv, dWaits, {tag, "/load"}, n);
                setReg(rt, rdv);
            end
            6'h2B: begin
                ea = a + imm;
                sbq.push_back('{ea, b});
                mMem[ea] = b;
                serveAccess(1'b1, ea, 32'h0, dWaits, {tag, "/store"}, n);
            end
            6'h04: begin
                base = 3;
                if (a == b) next = p4 + (imm << 2);
            end
            6'h02: begin
                base = 3;
                next = {p4[31:28], ins[25:0], 2'b00};
            end
`ifdef MCDP_JAL_EN
            6'h03: begin
                base = 3;
                setReg(31, p4);
                next = {p4[31:28], ins[25:0], 2'b00};
            end
`endif
            default: begin ill = 1'b1; base = 2; end
        endcase
        n = 0;
        while (memBus.memReq !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        nCompared++;
        if (cyc - s0 !== base + fWaits + dWaits) begin
            nMismatched++;
            $display("[TB] FAIL %s latency: got %0d required %0d", tag, cyc - s0, base + fWaits + dWaits);
        end
        nCompared++;
        if (pcQ !== next || memBus.memAddr !== next || memBus.memWE !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL %s next fetch: pcQ=%h addr=%h we=%b required %h/%h/0",
                     tag, pcQ, memBus.memAddr, memBus.memWE, next, next);
        end
        nCompared++;
        if (illegal !== ill) begin
            nMismatched++;
            $display("[TB] FAIL %s illegal: got %b required %b", tag, illegal, ill);
        end
        #1;
        nCompared++;
        if (illCount - illBefore !== (ill ? 1 : 0)) begin
            nMismatched++;
            $display("[TB] FAIL %s illegal pulses: got %0d required %0d", tag, illCount - illBefore, ill ? 1 : 0);
        end
        mPc = next;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        memBus.memReady = 1'b0;
        memBus.memRData = 32'h0;
        resetModel();
        repeat (3) @(negedge clock);
        nCompared++;
        if (memBus.memReq !== 1'b0 || pcQ !== RPC || instr !== 32'h0 || illegal !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset state: req=%b pcQ=%h instr=%h illegal=%b required 0/%h/0/0",
                     memBus.memReq, pcQ, instr, illegal, RPC);
        end
        resetN = 1'b1;
        #1;
        nCompared++;
        if (memBus.memReq !== 1'b1 || memBus.memAddr !== RPC || memBus.memWE !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL first request: req=%b addr=%h we=%b required 1/%h/0",
                     memBus.memReq, memBus.memAddr, memBus.memWE, RPC);
        end
    endtask

    task automatic test_alu();
        doInstr(itype(6'h08, 0, 1, 16'd5),        0, 0, "addi r1");
        doInstr(itype(6'h08, 0, 2, 16'hFFFD),     1, 0, "addi r2");
        doInstr(rtype(1, 2, 3, 6'h20),            0, 0, "add");
        doInstr(rtype(2, 1, 4, 6'h2A),            0, 0, "slt true");
        doInstr(rtype(1, 2, 6, 6'h22),            0, 0, "sub");
        doInstr(rtype(1, 2, 7, 6'h24),            0, 0, "and");
        doInstr(rtype(1, 2, 8, 6'h25),            0, 0, "or");
        doInstr(rtype(1, 2, 9, 6'h27),            0, 0, "nor");
        doInstr(rtype(1, 2, 10, 6'h2A),           0, 0, "slt false");
        doInstr(itype(6'h08, 0, 0, 16'd7),        0, 0, "addi r0");
        doInstr(itype(6'h08, 0, 11, 16'hFFFF),    0, 0, "addi -1");
        doInstr(itype(6'h08, 11, 11, 16'd1),      0, 0, "addi wrap");
        doInstr(itype(6'h2B, 0, 3, 16'h0010),     0, 0, "sw r3");
        doInstr(itype(6'h2B, 0, 4, 16'h0014),     0, 1, "sw r4");
        doInstr(itype(6'h2B, 0, 6, 16'h0018),     0, 0, "sw r6");
        doInstr(itype(6'h2B, 0, 7, 16'h001C),     0, 0, "sw r7");
        doInstr(itype(6'h2B, 0, 8, 16'h0020),     0, 0, "sw r8");
        doInstr(itype(6'h2B, 0, 9, 16'h0024),     0, 0, "sw r9");
        doInstr(itype(6'h2B, 0, 10, 16'h0028),    0, 0, "sw r10");
        doInstr(itype(6'h2B, 0, 0, 16'h002C),     0, 0, "sw r0");
        doInstr(itype(6'h2B, 0, 11, 16'h0030),    0, 0, "sw r11");
    endtask

    task automatic test_mem_stall();
        doInstr(itype(6'h2B, 0, 1, 16'h0008), 0, 2, "sw r1 stall");
        doInstr(itype(6'h23, 0, 5, 16'h0008), 0, 2, "lw r5 stall");
        doInstr(itype(6'h2B, 0, 5, 16'h000C), 0, 0, "sw r5");
    endtask

    task automatic test_control();
        doInstr(itype(6'h04, 1, 1, 16'hFFFF),     0, 0, "beq taken");
        doInstr(itype(6'h04, 1, 2, 16'h0005),     0, 0, "beq not taken");
        doInstr(jtype(6'h02, 26'h40),             0, 0, "j 0x40");
        doInstr(itype(6'h08, 0, 12, 16'h0180),    0, 0, "addi r12");
        doInstr(rtype(12, 0, 0, 6'h08),           0, 0, "jr r12");
        doInstr(rtype(1, 2, 13, 6'h3F),           0, 0, "bad funct");
    endtask

    task automatic test_jal();
        doInstr(itype(6'h08, 0, 12, 16'h0200),    0, 0, "addi r12 0x200");
        doInstr(rtype(12, 0, 0, 6'h08),           0, 0, "jr 0x200");
        doInstr(jtype(6'h03, 26'h90),             0, 0, "jal");
        doInstr(rtype(31, 0, 0, 6'h08),           0, 0, "jr r31");
        doInstr(itype(6'h2B, 0, 31, 16'h0050),    0, 0, "sw r31");
    endtask

    task automatic test_reset_mid_access();
        int s, n, wrBefore;
        serveAccess(1'b0, mPc, itype(6'h2B, 0, 1, 16'h0060), 0, "rstmid/fetch", s);
        n = 0;
        while (memBus.memReq !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        nCompared++;
        if (memBus.memReq !== 1'b1 || memBus.memWE !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL rstmid store request: req=%b we=%b required 1/1", memBus.memReq, memBus.memWE);
        end
        @(negedge clock);
        wrBefore = wrCount;
        resetN = 1'b0;
        #1;
        nCompared++;
        if (memBus.memReq !== 1'b0 || pcQ !== RPC) begin
            nMismatched++;
            $display("[TB] FAIL rstmid abort: req=%b pcQ=%h required 0/%h", memBus.memReq, pcQ, RPC);
        end
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        #1;
        nCompared++;
        if (memBus.memReq !== 1'b1 || memBus.memAddr !== RPC || memBus.memWE !== 1'b0 || wrCount !== wrBefore) begin
            nMismatched++;
            $display("[TB] FAIL rstmid restart: req=%b addr=%h we=%b writes=%0d required 1/%h/0/%0d",
                     memBus.memReq, memBus.memAddr, memBus.memWE, wrCount, RPC, wrBefore);
        end
        resetModel();
        doInstr(itype(6'h2B, 0, 1, 16'h0064), 0, 0, "sw r1 after reset");
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_mem_stall();
        test_control();
        test_jal();
        test_reset_mid_access();
        nCompared++;
        if (sbq.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL pending stores: got %0d left required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
